// File: rtl/phy_mgmt_pkg.sv
// Shared types and constants for the PHY management sequencer.
// States, MDIO register map and BMCR/BMSR bit positions.
package phy_mgmt_pkg;

   typedef enum logic [2:0] {
      S_RST_WR,
      S_RST_RD,
      S_CFG_WR,
      S_POLL_RD1,
      S_POLL_RD2,
      S_POLL_WAIT,
      S_ERROR
   } state_e;

   localparam logic [4:0] REG_BMCR = 5'd0;
   localparam logic [4:0] REG_BMSR = 5'd1;

   localparam int BIT_RST  = 15;
   localparam int BIT_LOOP = 14;
   localparam int BIT_SPD  = 13;
   localparam int BIT_DPX  = 8;
   localparam int BIT_LINK = 2;

   localparam logic [15:0] BMCR_RESET = 16'h8000;

   function automatic logic [15:0] bmcr_cfg(
      input logic loop,
      input logic spd,
      input logic dpx
   );
      logic [15:0] v;
      v           = '0;
      v[BIT_LOOP] = loop;
      v[BIT_SPD]  = spd;
      v[BIT_DPX]  = dpx;
      return v;
   endfunction

endpackage

// File: rtl/mdio_txn_if.sv
// Request/ack holding register toward the MDIO frame engine.
// Issues one transaction per start and pulses done with the read data.
module mdio_txn_if (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we_i,
   input  logic [4:0]  reg_i,
   input  logic [15:0] wdata_i,
   output logic        req,
   output logic        we,
   output logic [4:0]  reg_addr,
   output logic [15:0] wdata,
   input  logic        ack,
   input  logic [15:0] ack_rdata,
   output logic        done,
   output logic [15:0] rdata
);

   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [4:0]  reg_q, reg_d;
   logic [15:0] wdata_q, wdata_d;

   // Hold the request fields from start until the engine acknowledges.
   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      if (req_q) begin
         if (ack) req_d = 1'b0;
      end else if (start) begin
         req_d   = 1'b1;
         we_d    = we_i;
         reg_d   = reg_i;
         wdata_d = wdata_i;
      end
   end

   // Request register; reset drops the request at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         reg_q   <= '0;
         wdata_q <= '0;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
      end
   end

   // An ack with no request outstanding is not a completion.
   assign done     = req_q & ack;
   assign rdata    = ack_rdata;
   assign req      = req_q;
   assign we       = we_q;
   assign reg_addr = reg_q;
   assign wdata    = wdata_q;

endmodule

// File: rtl/phy_link_mgr.sv
// PHY bring-up and link polling over the shared MDIO engine.
// Resets and configures the PHY, then polls BMSR for link status.
module phy_link_mgr
   import phy_mgmt_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR     = 5'd1,
   parameter int         POLL_CYCLES  = 500000,
   parameter int         RST_POLL_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_loopback,
   input  logic        cfg_100M,
   input  logic        cfg_fulldpx,
   input  logic        restart,
   output logic        mdio_req,
   output logic        mdio_we,
   output logic [4:0]  mdio_phy,
   output logic [4:0]  mdio_reg,
   output logic [15:0] mdio_wdata,
   input  logic        mdio_ack,
   input  logic [15:0] mdio_rdata,
   output logic        link_up,
   output logic        speed_100,
   output logic        full_duplex,
   output logic        mac_tx_enable,
   output logic        busy,
   output logic        error
);

   localparam int TW = $clog2(POLL_CYCLES + 1);
   localparam int CW = $clog2(RST_POLL_MAX + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(POLL_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(RST_POLL_MAX);

   state_e        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          link_q, link_d;
   logic          err_q, err_d;
   logic          spd_q, spd_d;
   logic          dpx_q, dpx_d;
   logic          busy_q, busy_d;

   logic          txn_start;
   logic          txn_we;
   logic [4:0]    txn_reg;
   logic [15:0]   txn_wdata;
   logic          txn_done;
   logic [15:0]   txn_rdata;
   logic          in_txn;
   logic          apply;
   logic          unused_rdata;

   mdio_txn_if u_txn (
      .clk       (clk),
      .rst       (rst),
      .start     (txn_start),
      .we_i      (txn_we),
      .reg_i     (txn_reg),
      .wdata_i   (txn_wdata),
      .req       (mdio_req),
      .we        (mdio_we),
      .reg_addr  (mdio_reg),
      .wdata     (mdio_wdata),
      .ack       (mdio_ack),
      .ack_rdata (mdio_rdata),
      .done      (txn_done),
      .rdata     (txn_rdata)
   );

   // Sequencer: per-state request fields, completion handling, restart.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q | restart;
      link_d    = link_q;
      err_d     = err_q;
      spd_d     = spd_q;
      dpx_d     = dpx_q;
      txn_we    = 1'b0;
      txn_reg   = REG_BMCR;
      txn_wdata = '0;
      in_txn    = (state_q != S_POLL_WAIT) && (state_q != S_ERROR);

      unique case (state_q)
         S_RST_WR: begin
            txn_we    = 1'b1;
            txn_wdata = BMCR_RESET;
            if (txn_done) begin
               state_d = S_RST_RD;
               cnt_d   = CW'(1);
            end
         end
         S_RST_RD: begin
            if (txn_done) begin
               if (!txn_rdata[BIT_RST]) begin
                  state_d = S_CFG_WR;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_CFG_WR: begin
            txn_we    = 1'b1;
            txn_wdata = bmcr_cfg(cfg_loopback, cfg_100M, cfg_fulldpx);
            if (txn_done) begin
               spd_d   = mdio_wdata[BIT_SPD];
               dpx_d   = mdio_wdata[BIT_DPX];
               state_d = S_POLL_RD1;
            end
         end
         S_POLL_RD1: begin
            txn_reg = REG_BMSR;
            if (txn_done) state_d = S_POLL_RD2;
         end
         S_POLL_RD2: begin
            txn_reg = REG_BMSR;
            if (txn_done) begin
               link_d  = txn_rdata[BIT_LINK];
               tmr_d   = '0;
               state_d = S_POLL_WAIT;
            end
         end
         S_POLL_WAIT: begin
            if (tmr_q == TMR_LAST) state_d = S_POLL_RD1;
            else                   tmr_d   = tmr_q + TW'(1);
         end
         S_ERROR: begin
         end
         default: state_d = S_RST_WR;
      endcase

      // A pending restart waits for any outstanding request to complete,
      // then discards that completion and restarts from the PHY reset.
      apply     = pend_q & (~in_txn | ~mdio_req | txn_done);
      txn_start = in_txn & ~mdio_req & ~pend_q;
      if (apply) begin
         state_d = S_RST_WR;
         link_d  = 1'b0;
         err_d   = 1'b0;
         spd_d   = spd_q;
         dpx_d   = dpx_q;
         pend_d  = 1'b0;
      end

      busy_d = (state_d != S_POLL_WAIT) && (state_d != S_ERROR);
   end

   // State and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RST_WR;
         tmr_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         link_q  <= 1'b0;
         err_q   <= 1'b0;
         spd_q   <= 1'b0;
         dpx_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         link_q  <= link_d;
         err_q   <= err_d;
         spd_q   <= spd_d;
         dpx_q   <= dpx_d;
         busy_q  <= busy_d;
      end
   end

   assign unused_rdata  = ^{txn_rdata[14:3], txn_rdata[1:0]};
   assign mdio_phy      = PHY_ADDR;
   assign link_up       = link_q;
   assign speed_100     = spd_q;
   assign full_duplex   = dpx_q;
   assign error         = err_q;
   assign busy          = busy_q;
   assign mac_tx_enable = link_q & ~err_q;

endmodule
